// File: rtl/jtag_dr_ctrl_if.sv
// Bus between the TAP core and the user test-data-register controller.
// Optional err_cnt signal is present only when JTAG_DR_CTRL_ERRCNT_EN is defined.
interface jtag_dr_ctrl_if #(
    parameter int IR_W    = 5,
    parameter int DR_W    = 32,
    parameter int NUM_REG = 4
);
    logic [IR_W-1:0]         instructions;
    logic                    tdi;
    logic                    capture_en;
    logic                    shift_dr;
    logic                    update_en;
    logic [NUM_REG*DR_W-1:0] status_d;
    logic                    err_clr;
    logic                    so;
    logic                    bypass_sel;
    logic [NUM_REG*DR_W-1:0] cfg_q;
    logic [NUM_REG-1:0]      upd_pulse;
    logic                    err_sticky;
`ifdef JTAG_DR_CTRL_ERRCNT_EN
    logic [7:0]              err_cnt;
`endif

    modport master (
        output instructions, tdi, capture_en, shift_dr, update_en, status_d, err_clr,
`ifdef JTAG_DR_CTRL_ERRCNT_EN
        input  err_cnt,
`endif
        input  so, bypass_sel, cfg_q, upd_pulse, err_sticky
    );

    modport slave (
        input  instructions, tdi, capture_en, shift_dr, update_en, status_d, err_clr,
`ifdef JTAG_DR_CTRL_ERRCNT_EN
        output err_cnt,
`endif
        output so, bypass_sel, cfg_q, upd_pulse, err_sticky
    );
endinterface

// File: rtl/jtag_dr_ctrl.sv
// User test-data-register controller: one shared shift register serving NUM_REG registers.
// Define JTAG_DR_CTRL_ERRCNT_EN to add the saturating err_cnt output.
module jtag_dr_ctrl #(
    parameter int              IR_W    = 5,
    parameter int              DR_W    = 32,
    parameter int              NUM_REG = 4,
    parameter logic [IR_W-1:0] BASE_OP = IR_W'(8'h08),
    parameter logic [DR_W-1:0] CFG_RST = '0
) (
    input logic          tck,
    input logic          trst_n,
    jtag_dr_ctrl_if.slave bus
);
    localparam int              CNT_W    = $clog2(DR_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_W);
    localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(DR_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAP  = 2'd1,
        SHF  = 2'd2,
        OVR  = 2'd3
    } state_t;

    state_t                  state_r, state_n;
    logic [DR_W-1:0]         sr_r, sr_n;
    logic [CNT_W-1:0]        cnt_r, cnt_n;
    logic [NUM_REG*DR_W-1:0] cfg_r, cfg_n;
    logic [NUM_REG-1:0]      upd_r, upd_n;
    logic                    err_r, err_n;
    logic [IR_W-1:0]         idx_s;
    logic                    valid_s;
    logic                    abort_s;
    logic [DR_W-1:0]         cap_data_s;

    // Opcode decode; idx wraps for opcodes below BASE_OP, so one compare covers both ends
    always_comb begin
        idx_s   = bus.instructions - BASE_OP;
        valid_s = (idx_s < IR_W'(NUM_REG));
    end

    // Select the capture slice of the addressed register
    always_comb begin
        cap_data_s = '0;
        for (int k = 0; k < NUM_REG; k++) begin
            if (idx_s == IR_W'(k)) begin
                cap_data_s = bus.status_d[k*DR_W +: DR_W];
            end else begin
                cap_data_s = cap_data_s;
            end
        end
    end

    // Next-state and datapath: update beats capture, capture beats shift
    always_comb begin
        state_n = state_r;
        sr_n    = sr_r;
        cnt_n   = cnt_r;
        cfg_n   = cfg_r;
        upd_n   = '0;
        abort_s = 1'b0;
        if (bus.update_en && (state_r != IDLE)) begin
            state_n = IDLE;
            if ((cnt_r == CNT_FULL) && valid_s) begin
                for (int k = 0; k < NUM_REG; k++) begin
                    if (idx_s == IR_W'(k)) begin
                        cfg_n[k*DR_W +: DR_W] = sr_r;
                        upd_n[k]              = 1'b1;
                    end else begin
                        upd_n[k] = 1'b0;
                    end
                end
            end else begin
                abort_s = 1'b1;
            end
        end else if (bus.capture_en && valid_s) begin
            sr_n    = cap_data_s;
            cnt_n   = '0;
            state_n = CAP;
        end else if (bus.shift_dr && (state_r != IDLE)) begin
            sr_n = {bus.tdi, sr_r[DR_W-1:1]};
            case (state_r)
                CAP, SHF: begin
                    if (cnt_r == CNT_FULL) begin
                        cnt_n   = CNT_OVR;
                        state_n = OVR;
                    end else begin
                        cnt_n   = cnt_r + CNT_W'(1);
                        state_n = SHF;
                    end
                end
                OVR: begin
                    cnt_n   = CNT_OVR;
                    state_n = OVR;
                end
                default: begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // Sticky error: a new abort wins over a clear on the same edge
    always_comb begin
        if (abort_s) begin
            err_n = 1'b1;
        end else if (bus.err_clr) begin
            err_n = 1'b0;
        end else begin
            err_n = err_r;
        end
    end

    // State register
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Datapath registers; reset restores every cfg register
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            sr_r  <= '0;
            cnt_r <= '0;
            cfg_r <= {NUM_REG{CFG_RST}};
            upd_r <= '0;
            err_r <= 1'b0;
        end else begin
            sr_r  <= sr_n;
            cnt_r <= cnt_n;
            cfg_r <= cfg_n;
            upd_r <= upd_n;
            err_r <= err_n;
        end
    end

`ifdef JTAG_DR_CTRL_ERRCNT_EN
    logic [7:0] err_cnt_r, err_cnt_n;

    // Saturating abort counter; an abort coinciding with a clear leaves a count of one
    always_comb begin
        if (abort_s && bus.err_clr) begin
            err_cnt_n = 8'd1;
        end else if (abort_s) begin
            err_cnt_n = (err_cnt_r == 8'hFF) ? 8'hFF : (err_cnt_r + 8'd1);
        end else if (bus.err_clr) begin
            err_cnt_n = 8'd0;
        end else begin
            err_cnt_n = err_cnt_r;
        end
    end

    // Abort counter register
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            err_cnt_r <= 8'd0;
        end else begin
            err_cnt_r <= err_cnt_n;
        end
    end

    assign bus.err_cnt = err_cnt_r;
`endif

    assign bus.so         = valid_s ? sr_r[0] : 1'b0;
    assign bus.bypass_sel = ~valid_s;
    assign bus.cfg_q      = cfg_r;
    assign bus.upd_pulse  = upd_r;
    assign bus.err_sticky = err_r;
endmodule

// File: tb/tb_jtag_dr_ctrl.sv
// Scoreboard bench for jtag_dr_ctrl: stimulus pushes expectations, a negedge monitor checks them.
module tb_jtag_dr_ctrl;
    logic tck;
    logic trst_n;

    jtag_dr_ctrl_if #(.IR_W(5), .DR_W(32), .NUM_REG(4)) bus ();

    jtag_dr_ctrl dut (
        .tck    (tck),
        .trst_n (trst_n),
        .bus    (bus)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    typedef struct {
        string        name;
        logic [127:0] cfg;
        logic         err;
        logic         byp;
        logic         so;
        bit           chk_so;
        logic [7:0]   ecnt;
    } snap_t;

    typedef struct {
        logic [3:0]   upd;
        logic [127:0] cfg;
    } upd_t;

    snap_t snap_q[$];
    upd_t  upd_q[$];
    logic  so_q[$];

    logic [127:0] exp_cfg;
    logic [7:0]   exp_ecnt;
    logic         exp_err;
    logic         snap_req;
    logic         done;
    int           n_checks;
    int           n_errors;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic snap(input string name, input logic byp, input logic so, input bit chk_so);
        snap_t s;
        s.name   = name;
        s.cfg    = exp_cfg;
        s.err    = exp_err;
        s.byp    = byp;
        s.so     = so;
        s.chk_so = chk_so;
        s.ecnt   = exp_ecnt;
        snap_q.push_back(s);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
    endtask

    // Capture, shift n bits of data LSB-first, exit, then update (optionally with err_clr)
    task automatic dr_write(input logic [4:0] ir, input logic [31:0] data, input int n, input logic clr);
        bus.instructions = ir;
        bus.capture_en   = 1'b1;
        tick();
        bus.capture_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.shift_dr = 1'b1;
            bus.tdi      = (i < 32) ? data[i] : 1'b0;
            tick();
        end
        bus.shift_dr = 1'b0;
        bus.tdi      = 1'b0;
        tick();
        bus.update_en = 1'b1;
        bus.err_clr   = clr;
        tick();
        bus.update_en = 1'b0;
        bus.err_clr   = 1'b0;
    endtask

    task automatic push_upd(input logic [3:0] upd);
        upd_t u;
        u.upd = upd;
        u.cfg = exp_cfg;
        upd_q.push_back(u);
    endtask

    task automatic push_abort();
        exp_err  = 1'b1;
        exp_ecnt = (exp_ecnt == 8'hFF) ? 8'hFF : exp_ecnt + 8'd1;
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations
    initial begin
        snap_t s;
        upd_t  u;
        logic  b;
        forever begin
            @(negedge tck);
            if (done) break;
            if (bus.upd_pulse != 4'd0) begin
                if (upd_q.size() == 0) begin
                    check("unexpected_upd_pulse", {124'd0, bus.upd_pulse}, 128'd0);
                end else begin
                    u = upd_q.pop_front();
                    check("upd_pulse", {124'd0, bus.upd_pulse}, {124'd0, u.upd});
                    check("upd_cfg_q", bus.cfg_q, u.cfg);
                end
            end
            if (bus.shift_dr && (so_q.size() > 0)) begin
                b = so_q.pop_front();
                check("so_bit", {127'd0, bus.so}, {127'd0, b});
            end
            if (snap_req && (snap_q.size() > 0)) begin
                s = snap_q.pop_front();
                check({s.name, "_cfg_q"}, bus.cfg_q, s.cfg);
                check({s.name, "_err_sticky"}, {127'd0, bus.err_sticky}, {127'd0, s.err});
                check({s.name, "_bypass_sel"}, {127'd0, bus.bypass_sel}, {127'd0, s.byp});
                if (s.chk_so) check({s.name, "_so"}, {127'd0, bus.so}, {127'd0, s.so});
`ifdef JTAG_DR_CTRL_ERRCNT_EN
                check({s.name, "_err_cnt"}, {120'd0, bus.err_cnt}, {120'd0, s.ecnt});
`endif
            end
        end
        check("upd_q_drained", 128'(upd_q.size()), 128'd0);
        check("so_q_drained", 128'(so_q.size()), 128'd0);
        check("snap_q_drained", 128'(snap_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        logic [31:0] rb;
        n_checks = 0;
        n_errors = 0;
        done     = 1'b0;
        snap_req = 1'b0;
        exp_cfg  = 128'd0;
        exp_err  = 1'b0;
        exp_ecnt = 8'd0;
        trst_n           = 1'b0;
        bus.instructions = 5'h01;
        bus.tdi          = 1'b0;
        bus.capture_en   = 1'b0;
        bus.shift_dr     = 1'b0;
        bus.update_en    = 1'b0;
        bus.err_clr      = 1'b0;
        bus.status_d     = 128'd0;
        bus.status_d[3*32 +: 32] = 32'h12345678;
        bus.status_d[1*32 +: 32] = 32'h0000_0001;
        tick();
        snap("reset", 1'b1, 1'b0, 1'b1);
        trst_n = 1'b1;
        tick();

        // Write register 1
        bus.instructions = 5'h09;
        snap("ir09_decode", 1'b0, 1'b0, 1'b0);
        exp_cfg[1*32 +: 32] = 32'hDEADBEEF;
        push_upd(4'b0010);
        dr_write(5'h09, 32'hDEADBEEF, 32, 1'b0);
        snap("after_write1", 1'b0, 1'b0, 1'b0);

        // Read back register 3 capture data while writing a new value
        rb = 32'h12345678;
        for (int i = 0; i < 32; i++) so_q.push_back(rb[i]);
        exp_cfg[3*32 +: 32] = 32'hA5A50F0F;
        push_upd(4'b1000);
        dr_write(5'h0B, 32'hA5A50F0F, 32, 1'b0);
        snap("after_write3", 1'b0, 1'b0, 1'b0);

        // Short, long and zero-length shifts abort
        dr_write(5'h0A, 32'hCAFEF00D, 31, 1'b0);
        push_abort();
        snap("short_shift", 1'b0, 1'b0, 1'b0);
        dr_write(5'h0A, 32'hCAFEF00D, 33, 1'b0);
        push_abort();
        snap("long_shift", 1'b0, 1'b0, 1'b0);
        dr_write(5'h0A, 32'hCAFEF00D, 0, 1'b0);
        push_abort();
        snap("zero_shift", 1'b0, 1'b0, 1'b0);

        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        exp_err  = 1'b0;
        exp_ecnt = 8'd0;
        snap("err_clr", 1'b0, 1'b0, 1'b0);

        dr_write(5'h0A, 32'hCAFEF00D, 5, 1'b1);
        exp_err  = 1'b1;
        exp_ecnt = 8'd1;
        snap("clr_vs_abort", 1'b0, 1'b0, 1'b0);

        // Opcode just below the user range wraps to a large idx
        bus.instructions = 5'h07;
        snap("ir07_bypass", 1'b1, 1'b0, 1'b1);

        // Reset in the middle of a shift
        bus.instructions = 5'h08;
        bus.capture_en   = 1'b1;
        tick();
        bus.capture_en = 1'b0;
        bus.shift_dr   = 1'b1;
        bus.tdi        = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        bus.shift_dr = 1'b0;
        bus.tdi      = 1'b0;
        trst_n       = 1'b0;
        tick();
        trst_n        = 1'b1;
        exp_cfg       = 128'd0;
        exp_err       = 1'b0;
        exp_ecnt      = 8'd0;
        tick();
        bus.update_en = 1'b1;
        tick();
        bus.update_en = 1'b0;
        snap("midop_reset", 1'b0, 1'b0, 1'b1);

        // Bypass opcode: capture/shift/update have no effect
        bus.instructions = 5'h0C;
        snap("ir0c_bypass", 1'b1, 1'b0, 1'b1);
        dr_write(5'h0C, 32'hFFFFFFFF, 32, 1'b0);
        snap("bypass_after_op", 1'b1, 1'b0, 1'b1);

        tick();
        tick();
        done = 1'b1;
    end
endmodule
